// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front end (window generator and
// convolution stage).
package cnn_pkg;

  // Default image geometry and pixel width.
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_PIX_W = 8;

  // Convolution kernel edge length; the window is KSIZE x KSIZE.
  localparam int KSIZE = 3;

  // Window generator frame phase.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } win_state_t;

endpackage

// File: rtl/image_window_gen_if.sv
// Stream bundle between the image reader, the window generator and the
// convolution stage.
//
// Both streams use the same handshake: a transfer happens on a rising clock
// edge where valid && ready. The producer holds valid and its payload stable
// until that transfer; ready may depend combinationally on valid.
interface image_window_gen_if #(
  parameter int PIX_W = cnn_pkg::DEF_PIX_W
);
  // Pixel stream into the window generator.
  logic                                        in_valid;
  logic                                        in_ready;
  logic [PIX_W-1:0]                            in_pix;
  // Window stream out of the window generator.
  logic                                        win_valid;
  logic                                        win_ready;
  logic [cnn_pkg::KSIZE*cnn_pkg::KSIZE*PIX_W-1:0] win_data;
  logic                                        win_last;

  // Environment side: sends pixels, receives windows.
  modport master (
    output in_valid, in_pix, win_ready,
    input  in_ready, win_valid, win_data, win_last
  );

  // Window generator side.
  modport slave (
    input  in_valid, in_pix, win_ready,
    output in_ready, win_valid, win_data, win_last
  );
endinterface

// File: rtl/image_window_gen_line_buffer.sv
// Line buffer RAM: one word per image column holding the two previous rows.
// Read is combinational and sees the old word during a write to the same
// address, so the caller can shift rows in a single cycle.
module line_buffer #(
  parameter int DEPTH = cnn_pkg::DEF_IMG_W,
  parameter int WIDTH = 2 * cnn_pkg::DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Synchronous write; contents are never cleared because stale words are
  // only ever read back in rows that produce no window.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/image_window_gen.sv
// Raster pixel stream to 3x3 window converter. Emits only windows that lie
// fully inside the image, in raster order, one output register deep.
module image_window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  image_window_gen_if.slave  bus,
  output win_state_t         dbg_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NWIN = KSIZE * KSIZE;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  win_state_t            state;
  logic [PIX_W-1:0]      win_q [NWIN];
  logic [PIX_W-1:0]      win_n [NWIN];
  logic [NWIN*PIX_W-1:0] win_packed;
  logic [NWIN*PIX_W-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;
  logic [2*PIX_W-1:0]    lb_rd;
  logic [2*PIX_W-1:0]    lb_wr;
  logic [PIX_W-1:0]      lb0;
  logic [PIX_W-1:0]      lb1;
  logic                  accept;
  logic                  emit;
  logic                  frame_end;

  // DRAIN blocks input so the next frame cannot start until the final window
  // has left; otherwise a single output register needs no bubble.
  assign bus.in_ready = (state != DRAIN) && (!valid_q || bus.win_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign frame_end    = (row == ROW_LAST) && (col == COL_LAST);
  assign emit         = accept && (row >= RW'(2)) && (col >= CW'(2));

  // lb0 holds row-1, lb1 holds row-2 for the current column.
  assign {lb1, lb0} = lb_rd;
  assign lb_wr      = {lb0, bus.in_pix};

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2 * PIX_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb_wr),
    .rdata (lb_rd)
  );

  // Next window: shift left by one column and append {row-2,row-1,row}.
  always_comb begin
    for (int k = 0; k < NWIN; k++) begin
      win_n[k] = win_q[k];
    end
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        win_n[r*KSIZE + c] = win_q[r*KSIZE + c + 1];
      end
    end
    win_n[KSIZE-1]   = lb1;
    win_n[2*KSIZE-1] = lb0;
    win_n[NWIN-1]    = bus.in_pix;
  end

  // Flatten the next window, element k at [k*PIX_W +: PIX_W].
  always_comb begin
    win_packed = '0;
    for (int k = 0; k < NWIN; k++) begin
      win_packed[k*PIX_W +: PIX_W] = win_n[k];
    end
  end

  assign bus.win_valid = valid_q;
  assign bus.win_data  = data_q;
  assign bus.win_last  = last_q;
  assign dbg_state     = state;

  // Raster counters, window registers, output register and frame FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col     <= '0;
      row     <= '0;
      state   <= FILL;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      for (int k = 0; k < NWIN; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < NWIN; k++) begin
          win_q[k] <= win_n[k];
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // A new window overrides a handshake; a bare handshake empties the slot.
      if (emit) begin
        valid_q <= 1'b1;
        data_q  <= win_packed;
        last_q  <= frame_end;
      end else if (bus.win_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end

      case (state)
        FILL:    if (accept && (row == ROW_ONE) && (col == COL_LAST)) state <= RUN;
        RUN:     if (accept && frame_end) state <= DRAIN;
        DRAIN:   if (valid_q && bus.win_ready && last_q) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_image_window_gen.sv
// Directed bench for image_window_gen: full frames with steady and throttled
// output, input gaps, back-to-back frames and a mid-frame reset.
module tb_image_window_gen;
  import cnn_pkg::*;

  localparam int PW  = 10;
  localparam int W   = 28;
  localparam int H   = 28;
  localparam int NPX = W * H;
  localparam int NW  = (W - 2) * (H - 2);

  logic       clk;
  logic       rst;
  win_state_t dbg_state;

  image_window_gen_if #(.PIX_W(PW)) bus ();

  image_window_gen #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [9*PW:0]   exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              got_cnt  = 0;
  int              cur_kind = 0;
  bit              rdy_random = 0;
  logic [9*PW-1:0] first_ref0, first_ref1, last_ref0, first_ref;

  int ref_first0[9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
  int ref_first1[9] = '{1000, 999, 998, 972, 971, 970, 944, 943, 942};
  int ref_last0[9]  = '{725, 726, 727, 753, 754, 755, 781, 782, 783};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [9*PW-1:0] pack9(input int v[9]);
    logic [9*PW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v[k]);
    return w;
  endfunction

  function automatic logic [PW-1:0] pix(input int kind, input int r, input int c);
    int v;
    v = r * W + c;
    return (kind == 0) ? PW'(v) : PW'(1000 - v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_pixel(input logic [PW-1:0] p);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_pix   = p;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_wait", bus.in_ready, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "input stalled too long");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Queue the expected windows of a whole frame, then send npix pixels.
  task automatic send_frame(input int kind, input int gap_max, input int npix);
    logic [9*PW-1:0] w;
    int g;
    cur_kind  = kind;
    got_cnt   = 0;
    first_ref = (kind == 0) ? first_ref0 : first_ref1;
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = pix(kind, r - 2 + k / 3, c - 2 + k % 3);
        exp_q.push_back({(r == H - 1 && c == W - 1), w});
      end
    end
    for (int i = 0; i < npix; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        @(posedge clk); #1;
      end
      drive_pixel(pix(kind, i / W, i % W));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_q", exp_q.size(), 0);
    check("win_count", got_cnt, NW);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.win_valid, 1'b0);
    check({tag, "_last"},  bus.win_last, 1'b0);
    check({tag, "_data"},  bus.win_data, '0);
    check({tag, "_ready"}, bus.in_ready, 1'b1);
    check({tag, "_state"}, dbg_state, FILL);
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    bus.win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.win_ready = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int m_row, m_col;
    bit prev_qual, prev_hs, prev_valid, stalled, cur_acc, cur_hs, exp_valid, held_last;
    logic [9*PW-1:0] held_data;
    logic [9*PW:0]   e;
    m_row = 0; m_col = 0; prev_qual = 0; prev_hs = 0; prev_valid = 0; stalled = 0;
    held_last = 0; held_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_row = 0; m_col = 0; prev_qual = 0; prev_hs = 0; prev_valid = 0; stalled = 0;
      end else begin
        exp_valid = prev_qual ? 1'b1 : (prev_hs ? 1'b0 : prev_valid);
        check("valid_model", bus.win_valid, exp_valid);
        cur_acc = bus.in_valid && bus.in_ready;
        cur_hs  = bus.win_valid && bus.win_ready;
        if (bus.win_valid && !bus.win_ready) begin
          check("stall_in_ready", bus.in_ready, 1'b0);
          if (stalled) begin
            check("stall_data", bus.win_data, held_data);
            check("stall_last", bus.win_last, held_last);
          end
          stalled   = 1;
          held_data = bus.win_data;
          held_last = bus.win_last;
        end else begin
          stalled = 0;
        end
        if (dbg_state == DRAIN) check("drain_in_ready", bus.in_ready, 1'b0);
        if (cur_hs) begin
          if (exp_q.size() == 0) begin
            check("win_extra", bus.win_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("win_data", bus.win_data, e[9*PW-1:0]);
            check("win_last", bus.win_last, e[9*PW]);
            if (got_cnt == 0) check("first_win", bus.win_data, first_ref);
            if (e[9*PW] && cur_kind == 0) check("final_win", bus.win_data, last_ref0);
          end
          got_cnt++;
        end
        prev_qual  = cur_acc && m_row >= 2 && m_col >= 2;
        prev_hs    = cur_hs;
        prev_valid = bus.win_valid;
        if (cur_acc) begin
          if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
          end else begin
            m_col = m_col + 1;
          end
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    first_ref0 = pack9(ref_first0);
    first_ref1 = pack9(ref_first1);
    last_ref0  = pack9(ref_last0);
    first_ref  = first_ref0;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pix   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Steady stream: first window, count, final window with win_last.
    send_frame(0, 0, NPX);
    wait_drain();

    // Throttled downstream.
    rdy_random = 1;
    send_frame(0, 0, NPX);
    wait_drain();
    rdy_random = 0;

    // Input gaps of 0-5 cycles.
    send_frame(0, 5, NPX);
    wait_drain();

    // Back-to-back frames; frame 2 waits out DRAIN.
    send_frame(0, 0, NPX);
    @(negedge clk);
    check("t5_drain_state", dbg_state, DRAIN);
    check("t5_drain_ready", bus.in_ready, 1'b0);
    check("t5_drain_last",  bus.win_last, 1'b1);
    @(posedge clk); #1;
    check("t5_fill_state", dbg_state, FILL);
    check("t5_ready_back", bus.in_ready, 1'b1);
    check("t5_f1_count",   got_cnt, NW);
    send_frame(1, 0, NPX);
    wait_drain();

    // Mid-frame asynchronous reset at pixel 400.
    send_frame(0, 0, 400);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    send_frame(0, 0, NPX);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
